// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit engines.
//   - receive FSM state encoding
//   - default bit-time counter width and maximum data bits per frame
//   - parity-sense encodings for the ohel control bit
package uart_pkg;

  localparam int BIT_CNT_W_DEF = 19;
  localparam int DATA_MAX_DEF  = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-time up-counter with a single-cycle tick.
//   clk, rst      clock and asynchronous active-high reset
//   i_clear       hold the counter at zero, suppress the tick
//   i_half        1 = tick at (bit_time>>1)-1, 0 = tick at bit_time-1
//   i_bit_time    clock cycles per bit
//   o_tick        high for one cycle when the count reaches the target;
//                 the counter wraps to zero on that same edge
module uart_bit_timer #(
  parameter int BIT_CNT_W = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_half,
  input  logic [BIT_CNT_W-1:0] i_bit_time,
  output logic                 o_tick
);

  logic [BIT_CNT_W-1:0] r_cnt;
  logic [BIT_CNT_W-1:0] w_target;

  assign w_target = i_half ? ((i_bit_time >> 1) - BIT_CNT_W'(1))
                           : (i_bit_time - BIT_CNT_W'(1));

  assign o_tick = ~i_clear & (r_cnt == w_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receive datapath.
// Detects the start bit on the synchronized line, samples data, parity and
// stop bits at mid-bit, and presents the character with status flags.
//   clk, rst       clock and asynchronous active-high reset
//   rx_sync        synchronized serial input, idle high
//   bit_time       clock cycles per bit (>= 4)
//   eight          1 = 8 data bits, 0 = 7 data bits
//   pen, ohel      parity enable, parity sense (1 = odd)
//   rd_strobe      host read pulse, clears rx_rdy and ovf
//   rx_data        received character, LSB first on the line
//   rx_rdy         character available
//   perr, ferr     parity / framing error of the last frame
//   ovf            frame completed while rx_rdy was still set
//
// state     | meaning
// ----------+--------------------------------------------------------
// RX_IDLE   | wait for line high (arm), then a falling edge
// RX_START  | wait half a bit, confirm the start bit is still low
// RX_DATA   | sample one data bit per bit time, LSB first
// RX_PARITY | sample the parity bit and compare with the data XOR
// RX_STOP   | sample the stop bit, hand the frame to the host side
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int BIT_CNT_W = BIT_CNT_W_DEF,
  parameter int DATA_MAX  = DATA_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_sync,
  input  logic [BIT_CNT_W-1:0] bit_time,
  input  logic                 eight,
  input  logic                 pen,
  input  logic                 ohel,
  input  logic                 rd_strobe,
  output logic [DATA_MAX-1:0]  rx_data,
  output logic                 rx_rdy,
  output logic                 perr,
  output logic                 ferr,
  output logic                 ovf
);

  localparam int IDX_W = $clog2(DATA_MAX);

  rx_state_t            r_state;
  logic                 r_armed;
  logic [BIT_CNT_W-1:0] r_bit_time;
  logic                 r_eight;
  logic                 r_pen;
  logic                 r_ohel;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_MAX-1:0]  r_shift;
  logic                 r_par;
  logic                 r_par_err;
  logic                 r_done;
  logic                 r_perr_nxt;
  logic                 r_ferr_nxt;

  logic                 w_tick;
  logic                 w_par_exp;
  logic [IDX_W-1:0]     w_last_idx;

  assign w_par_exp  = (r_ohel == PAR_ODD) ? ~r_par : r_par;
  assign w_last_idx = r_eight ? IDX_W'(DATA_MAX - 1) : IDX_W'(DATA_MAX - 2);

  // Held clear in IDLE so the count starts at zero the cycle after detection;
  // the tick itself wraps the counter between samples.
  uart_bit_timer #(
    .BIT_CNT_W (BIT_CNT_W)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (r_state == RX_IDLE),
    .i_half     (r_state == RX_START),
    .i_bit_time (r_bit_time),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RX_IDLE;
      r_armed    <= 1'b0;
      r_bit_time <= '0;
      r_eight    <= 1'b0;
      r_pen      <= 1'b0;
      r_ohel     <= 1'b0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_par_err  <= 1'b0;
      r_done     <= 1'b0;
      r_perr_nxt <= 1'b0;
      r_ferr_nxt <= 1'b0;
      rx_data    <= '0;
      rx_rdy     <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Host side: a completing frame takes priority over a read in the
      // same cycle, but the read still cancels any overrun.
      if (r_done) begin
        rx_data <= r_shift;
        perr    <= r_perr_nxt;
        ferr    <= r_ferr_nxt;
        rx_rdy  <= 1'b1;
        if (rd_strobe) begin
          ovf <= 1'b0;
        end else if (rx_rdy) begin
          ovf <= 1'b1;
        end
      end else if (rd_strobe) begin
        rx_rdy <= 1'b0;
        ovf    <= 1'b0;
      end

      case (r_state)
        RX_IDLE: begin
          if (rx_sync) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state    <= RX_START;
            r_bit_time <= bit_time;
            r_eight    <= eight;
            r_pen      <= pen;
            r_ohel     <= ohel;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_par_err  <= 1'b0;
          end
        end
        RX_START: begin
          if (w_tick) begin
            // Line back high at mid-start: glitch, stay armed.
            if (rx_sync) begin
              r_state <= RX_IDLE;
            end else begin
              r_idx   <= '0;
              r_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (w_tick) begin
            r_shift[r_idx] <= rx_sync;
            r_par          <= r_par ^ rx_sync;
            if (r_idx == w_last_idx) begin
              r_state <= r_pen ? RX_PARITY : RX_STOP;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        RX_PARITY: begin
          if (w_tick) begin
            r_par_err <= rx_sync ^ w_par_exp;
            r_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            r_done     <= 1'b1;
            r_ferr_nxt <= ~rx_sync;
            r_perr_nxt <= r_pen & r_par_err;
            // A low stop bit may be a break: re-arm only once the line is high.
            r_armed    <= rx_sync;
            r_state    <= RX_IDLE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
module tb_uart_rx_engine;

  localparam int BW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_sync;
  logic [BW-1:0] bit_time;
  logic          eight, pen, ohel, rd_strobe;
  logic [7:0]    rx_data;
  logic          rx_rdy, perr, ferr, ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = -1;
  logic rdy_q  = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  uart_rx_engine #(.BIT_CNT_W(BW), .DATA_MAX(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_sync   (rx_sync),
    .bit_time  (bit_time),
    .eight     (eight),
    .pen       (pen),
    .ohel      (ohel),
    .rd_strobe (rd_strobe),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .perr      (perr),
    .ferr      (ferr),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records the index of the clock edge at which rx_rdy rose.
  always @(posedge clk) begin
    #1;
    if (rx_rdy && !rdy_q) rise_cyc = cyc;
    rdy_q = rx_rdy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Drives one frame starting at the next falling clock edge and, if push is
  // set, queues the expected result computed from the current config.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit p_en,
                            input bit par_bit, input bit stop_bit, input bit push);
    exp_t e;
    int bt;
    logic x;
    bt = int'(bit_time);
    @(negedge clk);
    e.done_cyc = cyc + 1 + bt / 2 + bt * (1 + nb + (p_en ? 1 : 0)) + 1;
    e.data     = (nb == 8) ? d : {1'b0, d[6:0]};
    x          = ^e.data;
    e.perr     = p_en && (par_bit != (ohel ? ~x : x));
    e.ferr     = !stop_bit;
    if (push) sb.push_back(e);
    rx_sync = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx_sync = d[i];
      repeat (bt) @(negedge clk);
    end
    if (p_en) begin
      rx_sync = par_bit;
      repeat (bt) @(negedge clk);
    end
    rx_sync = stop_bit;
    repeat (bt) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_sync = 1'b1; bit_time = BW'(16);
    eight = 1'b1; pen = 1'b0; ohel = 1'b0; rd_strobe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_rdy got=%b exp=0", rx_rdy); end
    n_checks++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr got=%b exp=0", perr); end
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_8n1();
    exp_t e;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 400 && !rx_rdy; k++) @(negedge clk);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL 8n1_queue got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rise_cyc !== e.done_cyc) begin n_fail++; $display("FAIL 8n1_latency got=%0d exp=%0d", rise_cyc, e.done_cyc); end
    n_checks++; if (rx_rdy !== 1'b1) begin n_fail++; $display("FAIL 8n1_rx_rdy got=%b exp=1", rx_rdy); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL 8n1_rx_data got=%h exp=%h", rx_data, e.data); end
    n_checks++; if (perr !== e.perr || ferr !== e.ferr) begin n_fail++; $display("FAIL 8n1_flags got=%b%b exp=%b%b", perr, ferr, e.perr, e.ferr); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL 8n1_ovf got=%b exp=0", ovf); end
    read_pulse();
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL 8n1_read_rdy got=%b exp=0", rx_rdy); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL 8n1_read_hold got=%h exp=%h", rx_data, e.data); end
  endtask

  task automatic test_parity();
    exp_t e;
    eight = 1'b0; pen = 1'b1; ohel = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 400 && !rx_rdy; k++) @(negedge clk);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL par_ok_queue got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rise_cyc !== e.done_cyc) begin n_fail++; $display("FAIL par_ok_latency got=%0d exp=%0d", rise_cyc, e.done_cyc); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL par_ok_rx_data got=%h exp=%h", rx_data, e.data); end
    n_checks++; if (perr !== e.perr) begin n_fail++; $display("FAIL par_ok_perr got=%b exp=%b", perr, e.perr); end
    read_pulse();
    // Config inputs change mid-frame; the frame must still be 7O1.
    fork
      send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1);
      begin
        repeat (30) @(negedge clk);
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
      end
    join
    for (int k = 0; k < 400 && !rx_rdy; k++) @(negedge clk);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL par_bad_queue got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rx_rdy !== 1'b1) begin n_fail++; $display("FAIL par_bad_rx_rdy got=%b exp=1", rx_rdy); end
    n_checks++; if (perr !== e.perr) begin n_fail++; $display("FAIL par_bad_perr got=%b exp=%b", perr, e.perr); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL par_bad_rx_data got=%h exp=%h", rx_data, e.data); end
    read_pulse();
  endtask

  task automatic test_glitch();
    exp_t e;
    @(negedge clk);
    rx_sync = 1'b0;
    repeat (6) @(negedge clk);
    rx_sync = 1'b1;
    repeat (200) @(negedge clk);
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_rx_rdy got=%b exp=0", rx_rdy); end
    send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 400 && !rx_rdy; k++) @(negedge clk);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL glitch_queue got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rise_cyc !== e.done_cyc) begin n_fail++; $display("FAIL glitch_latency got=%0d exp=%0d", rise_cyc, e.done_cyc); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL glitch_rx_data got=%h exp=%h", rx_data, e.data); end
    n_checks++; if (ferr !== e.ferr || perr !== e.perr) begin n_fail++; $display("FAIL glitch_flags got=%b%b exp=%b%b", perr, ferr, e.perr, e.ferr); end
    read_pulse();
  endtask

  task automatic test_break();
    exp_t e;
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 400 && !rx_rdy; k++) @(negedge clk);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL break_queue got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rx_rdy !== 1'b1) begin n_fail++; $display("FAIL break_rx_rdy got=%b exp=1", rx_rdy); end
    n_checks++; if (ferr !== e.ferr) begin n_fail++; $display("FAIL break_ferr got=%b exp=%b", ferr, e.ferr); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL break_rx_data got=%h exp=%h", rx_data, e.data); end
    read_pulse();
    repeat (38) @(negedge clk);
    rx_sync = 1'b1;
    repeat (200) @(negedge clk);
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL break_no_restart got=%b exp=0", rx_rdy); end
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 400 && !rx_rdy; k++) @(negedge clk);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL break_next_queue got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL break_next_rx_data got=%h exp=%h", rx_data, e.data); end
    n_checks++; if (ferr !== e.ferr) begin n_fail++; $display("FAIL break_next_ferr got=%b exp=%b", ferr, e.ferr); end
    read_pulse();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int t;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_q1 got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rx_data !== e.data || ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_first got=%h/%b exp=%h/0", rx_data, ovf, e.data); end
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_q2 got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL b2b_rx_data got=%h exp=%h", rx_data, e.data); end
    n_checks++; if (ovf !== 1'b1 || rx_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf got=%b rdy=%b exp=1/1", ovf, rx_rdy); end
    read_pulse();
    n_checks++; if (rx_rdy !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_read got=%b/%b exp=0/0", rx_rdy, ovf); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL b2b_read_hold got=%h exp=%h", rx_data, e.data); end
    // Rebuild an overrun, then read exactly on the completion edge.
    send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf2 got=%b exp=1", ovf); end
    fork
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 20 && sb.size() == 0; k++) @(negedge clk);
        t = (sb.size() != 0) ? sb[sb.size() - 1].done_cyc : 0;
        for (int k = 0; k < 400 && cyc < t - 1; k++) @(negedge clk);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
      end
    join
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL coinc_queue got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rx_rdy !== 1'b1) begin n_fail++; $display("FAIL coinc_rx_rdy got=%b exp=1", rx_rdy); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL coinc_ovf got=%b exp=0", ovf); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL coinc_rx_data got=%h exp=%h", rx_data, e.data); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    // rx_rdy and rx_data are still set from the previous test.
    fork
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (rx_data !== 8'h00 || rx_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_data got=%h/%b exp=00/0", rx_data, rx_rdy); end
        n_checks++; if (perr !== 1'b0 || ferr !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got=%b%b%b exp=000", perr, ferr, ovf); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (200) @(negedge clk);
    n_checks++; if (rx_rdy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_partial got=%b exp=0", rx_rdy); end
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 400 && !rx_rdy; k++) @(negedge clk);
    n_checks++; if (sb.size() == 0) begin n_fail++; $display("FAIL rstmid_queue got=empty exp=entry"); end else e = sb.pop_front();
    n_checks++; if (rise_cyc !== e.done_cyc) begin n_fail++; $display("FAIL rstmid_latency got=%0d exp=%0d", rise_cyc, e.done_cyc); end
    n_checks++; if (rx_data !== e.data) begin n_fail++; $display("FAIL rstmid_rx_data got=%h exp=%h", rx_data, e.data); end
    n_checks++; if (perr !== e.perr || ferr !== e.ferr || ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags2 got=%b%b%b exp=%b%b0", perr, ferr, ovf, e.perr, e.ferr); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
